// File: rtl/gpmc_pkg.sv
// Shared state encoding and strobe levels for the GPMC register-port arbiter.
package gpmc_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 4;

  // Bridge strobes are active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {IDLE, ARB, WAIT, STROBE, CAPTURE, DONE} state_t;
endpackage

// File: rtl/gpmc_reg_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);
  logic [IW-1:0] j;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = j;
      end
    end
  end
endmodule

// File: rtl/gpmc_reg_arbiter.sv
// Round-robin sequencer sharing the GPMC bridge register port between NUM_REQ requesters.
// Optional busy-wait abort built when GPMC_ARB_TIMEOUT_EN is defined.
module gpmc_reg_arbiter
  import gpmc_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [NUM_REQ-1:0]            err,
  output logic                          reg_cs,
  output logic                          reg_oe,
  output logic                          reg_we,
  output logic [ADDR_WIDTH-1:0]         reg_addr,
  output logic [DATA_WIDTH-1:0]         reg_wdata,
  input  logic [DATA_WIDTH-1:0]         reg_rdata,
  input  logic                          reg_busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                             state;
  logic [IW-1:0]                      ptr, gidx, nxt_ptr, arb_idx;
  logic                               arb_vld, g_we;
  logic [ADDR_WIDTH-1:0]              g_addr;
  logic [DATA_WIDTH-1:0]              g_wdata;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign nxt_ptr = (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

`ifdef GPMC_ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TO_W-1:0] to_cnt;
`else
  assign err = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      g_we      <= 1'b0;
      g_addr    <= '0;
      g_wdata   <= '0;
      ack       <= '0;
      rdata     <= '0;
      reg_cs    <= STROBE_OFF;
      reg_oe    <= STROBE_OFF;
      reg_we    <= STROBE_OFF;
      reg_addr  <= '0;
      reg_wdata <= '0;
`ifdef GPMC_ARB_TIMEOUT_EN
      err       <= '0;
      to_cnt    <= '0;
`endif
    end else begin
      ack <= '0;
`ifdef GPMC_ARB_TIMEOUT_EN
      err <= '0;
`endif
      case (state)
        IDLE: if (|req) state <= ARB;
        // Requests may have dropped since IDLE; fall back if nobody is left.
        ARB: begin
          if (arb_vld) begin
            gidx    <= arb_idx;
            g_we    <= req_we[arb_idx];
            g_addr  <= addr_v[arb_idx];
            g_wdata <= wdata_v[arb_idx];
            state   <= WAIT;
          end else begin
            state   <= IDLE;
          end
`ifdef GPMC_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        WAIT: begin
          if (!reg_busy) begin
            reg_cs    <= STROBE_ON;
            reg_addr  <= g_addr;
            reg_wdata <= g_wdata;
            state     <= STROBE;
          end
`ifdef GPMC_ARB_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            err[gidx] <= 1'b1;
            ptr       <= nxt_ptr;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        STROBE: begin
          if (g_we) reg_we <= STROBE_ON;
          else      reg_oe <= STROBE_ON;
          state <= CAPTURE;
        end
        CAPTURE: begin
          reg_oe <= STROBE_OFF;
          reg_we <= STROBE_OFF;
          if (!g_we) rdata <= reg_rdata;
          state <= DONE;
        end
        DONE: begin
          reg_cs    <= STROBE_OFF;
          ack[gidx] <= 1'b1;
          ptr       <= nxt_ptr;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/gpmc_reg_arbiter.md
Name: gpmc_reg_arbiter

Overview:
- Round-robin arbiter/sequencer sharing the FPGA-side register port of the GPMC synchronous bridge between NUM_REQ fabric requesters (LED driver, PMOD drivers, button sampler).
- Each requester issues single read or write transactions.
- The block serialises them, drives the bridge's active-low cs/oe/we strobes, defers to the bridge's busy flag while the ARM host owns the register file, and returns read data with a one-cycle ack.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 16, register data width
- ADDR_WIDTH, 4, register address width
- TIMEOUT_CYC, 255, busy-wait cycles before abort (used only with the optional feature)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- req  input  NUM_REQ  per-requester request, held high until ack
- req_we  input  NUM_REQ  1=write, 0=read, per requester
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data
- ack  output  NUM_REQ  one-cycle completion pulse to the granted requester
- rdata  output  DATA_WIDTH  read data, valid in the ack cycle
- err  output  NUM_REQ  one-cycle abort pulse (timeout builds only; tied 0 otherwise)
- reg_cs  output  1  bridge chip select, active-low
- reg_oe  output  1  bridge read strobe, active-low
- reg_we  output  1  bridge write strobe, active-low
- reg_addr  output  ADDR_WIDTH  bridge address
- reg_wdata  output  DATA_WIDTH  bridge write data
- reg_rdata  input  DATA_WIDTH  bridge read data
- reg_busy  input  1  bridge busy (ARM access in progress)

Behaviour:
- Reset (rst_n low at a clk edge) forces the following, regardless of any transaction in flight:
  - reg_cs/oe/we=1; reg_addr=0; reg_wdata=0; rdata=0; ack=0; err=0
  - round-robin pointer=0; state=IDLE
  - In-flight transaction is dropped with no ack.
- States: IDLE, ARB, WAIT, STROBE, CAPTURE, DONE.
- IDLE: if any req bit is set, go to ARB next cycle.
- ARB:
  - Grant the first set req at or after the pointer, wrapping modulo NUM_REQ.
  - Latch the granted index, we, addr and wdata into internal registers.
  - Go to WAIT.
- WAIT:
  - reg_busy=1: stay in WAIT, strobes deasserted.
  - reg_busy=0: assert reg_cs=0 and drive reg_addr/reg_wdata from the latched values; go to STROBE.
- STROBE:
  - Write: reg_we=0 for exactly one cycle.
  - Read: reg_oe=0 for exactly one cycle.
  - Go to CAPTURE.
- CAPTURE:
  - Deassert strobes; reg_cs stays 0.
  - Read: register reg_rdata into rdata at the end of this cycle.
  - Go to DONE.
- DONE:
  - reg_cs=1; ack[granted]=1 for one cycle.
  - Pointer = granted+1, wrapping NUM_REQ-1 to 0.
  - Go to IDLE.
- Latency from req to ack with bridge idle: 5 cycles (IDLE→ARB→WAIT→STROBE→CAPTURE→DONE).
- Arbitration happens only in ARB. Requests asserted or changed mid-transaction are not sampled until the next ARB.
- The granted requester's inputs are latched in ARB, so later changes do not affect the transaction.
- reg_busy rising during STROBE/CAPTURE is ignored; the transaction completes.
- Requester dropping req before ack: the transaction still completes and ack is still issued.
- rdata holds its last value after ack; it is not cleared. rdata is unchanged by writes.
- At most one ack bit is set in any cycle; ack and err are mutually exclusive.

Optional Feature:
- Macro GPMC_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter runs in WAIT and clears on WAIT entry.
  - When it reaches TIMEOUT_CYC: go to IDLE, pulse err[granted] for one cycle, no ack, no strobes issued, pointer advances past the granted requester.
- Undefined:
  - WAIT lasts indefinitely while reg_busy=1.
  - err is tied to 0 and no counter logic is built.

Decomposition:
- Shared package gpmc_pkg: state encoding constants (IDLE..DONE), default DATA_WIDTH/ADDR_WIDTH, strobe-level constants (STROBE_ON=1'b0, STROBE_OFF=1'b1).
- One sub-module, rr_arbiter: combinational priority pick from req and pointer, returning granted index and a valid flag. Reusable elsewhere.

Test Plan:
- Single read: reset, req[1]=1, req_we=0, addr=3, reg_rdata=16'hBEEF, busy=0 → reg_oe low exactly 1 cycle with reg_addr=3; ack[1] 5 cycles after req; rdata=16'hBEEF.
- Single write: req[2], we=1, addr=5, wdata=16'h000A → reg_we low 1 cycle, reg_cs low 3 cycles, reg_wdata=16'h000A; ack[2] pulse; rdata unchanged.
- Fairness: req=4'b1111 held, re-asserted after each ack → ack order 0,1,2,3,0; after ack[3] the pointer wraps and ack[0] is next.
- Busy stall: reg_busy=1 for 20 cycles after grant → no strobes during stall; reg_cs falls the cycle after busy drops; ack follows 3 cycles later.
- Reset mid-op: rst_n low during STROBE → next cycle all strobes high, no ack; a fresh req afterwards is served from requester 0 priority.
- Timeout (GPMC_ARB_TIMEOUT_EN, TIMEOUT_CYC=10): busy stuck at 1 → err[granted] pulses after 10 WAIT cycles; no ack; the next requester is served once busy clears.
